meter_timer: RTL and testbench

Remaining-time core of the parking meter. It accepts coin buttons and preset-load switches and counts the balance down once per second, saturating at 9999 s. It drives the 16-bit binary `Rem_Time` consumed by the 7-segment display stage, plus a `Blank` flag that implements the low-time and expired flash patterns.

---
 rtl/meter_pkg.sv | 38 +++
 rtl/meter_btn_edge.sv | 67 ++++++
 rtl/meter_timer.sv | 87 ++++++++
 tb/tb_meter_timer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/meter_pkg.sv
// Shared constants and the blanking rule for the parking-meter remaining-time core.
package meter_pkg;

    localparam int TIME_W     = 16;
    localparam int SUM_W      = TIME_W + 1;
    localparam int MAX_TIME   = 9999;

    localparam int ADD_A      = 10;
    localparam int ADD_B      = 180;
    localparam int ADD_C      = 200;
    localparam int ADD_D      = 550;

    localparam int LOAD_A     = 10;
    localparam int LOAD_B     = 205;
    localparam int LOW_THRESH = 200;

    typedef enum int unsigned {
        BTN_ADD_10   = 0,
        BTN_ADD_180  = 1,
        BTN_ADD_200  = 2,
        BTN_ADD_550  = 3,
        BTN_LOAD_10  = 4,
        BTN_LOAD_205 = 5
    } btn_e;

    localparam int N_BTN = 6;

    // Expired flashes at 0.5 s from the prescaler phase; low time blanks even seconds.
    function automatic logic blank_of(input logic [TIME_W-1:0] rem, input logic ph);
        if (rem == '0)
            return ph;
        else if (rem < TIME_W'(LOW_THRESH))
            return ~rem[0];
        else
            return 1'b0;
    endfunction

endpackage

// File: rtl/meter_btn_edge.sv
// Synchronizer, optional debouncer (METER_DEBOUNCE_EN) and rising-edge detector
// turning one raw button into a single-cycle Pulse.
module meter_btn_edge
`ifdef METER_DEBOUNCE_EN
#(
    parameter int DB_CYCLES = 1_000_000
)
`endif
(
    input  logic SYS_CLK,
    input  logic RESET_N,
    input  logic Btn,
    output logic Pulse
);

    logic sync_q1;
    logic sync_q2;
    logic level;
    logic level_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge SYS_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= Btn;
            sync_q2 <= sync_q1;
        end
    end

`ifdef METER_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DB_CYCLES + 1);

    logic [CNT_W-1:0] db_cnt;
    logic             db_level;

    // Filtered level follows the synchronized input only after DB_CYCLES stable cycles.
    always_ff @(posedge SYS_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            db_cnt   <= '0;
            db_level <= 1'b0;
        end else if (sync_q2 == db_level) begin
            db_cnt   <= '0;
        end else if (db_cnt == CNT_W'(DB_CYCLES - 1)) begin
            db_cnt   <= '0;
            db_level <= sync_q2;
        end else begin
            db_cnt   <= db_cnt + 1'b1;
        end
    end

    assign level = db_level;
`else
    assign level = sync_q2;
`endif

    always_ff @(posedge SYS_CLK or negedge RESET_N) begin
        if (!RESET_N)
            level_q <= 1'b0;
        else
            level_q <= level;
    end

    assign Pulse = level & ~level_q;

endmodule

// File: rtl/meter_timer.sv
// Parking-meter remaining-time core: coin adds, preset loads, 1 s countdown with
// 9999 s saturation and the Blank flash register. Optional debounce: METER_DEBOUNCE_EN.
module meter_timer
    import meter_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic              SYS_CLK,
    input  logic              RESET_N,
    input  logic              Add_10,
    input  logic              Add_180,
    input  logic              Add_200,
    input  logic              Add_550,
    input  logic              Load_10,
    input  logic              Load_205,
    output logic [TIME_W-1:0] Rem_Time,
    output logic              Blank
);

    localparam int             PRE_W    = $clog2(CLK_HZ);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);
    localparam logic [PRE_W-1:0] PRE_HALF = PRE_W'(CLK_HZ / 2);

    logic [N_BTN-1:0]  raw;
    logic [N_BTN-1:0]  pulse;
    logic [PRE_W-1:0]  pre;
    logic [PRE_W-1:0]  pre_nxt;
    logic [TIME_W-1:0] rem_nxt;
    logic [SUM_W-1:0]  sum;
    logic              tick;
    logic              blank_nxt;

    assign raw = {Load_205, Load_10, Add_550, Add_200, Add_180, Add_10};

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        meter_btn_edge
`ifdef METER_DEBOUNCE_EN
        #(.DB_CYCLES(DB_CYCLES))
`endif
        u_btn (
            .SYS_CLK (SYS_CLK),
            .RESET_N (RESET_N),
            .Btn     (raw[i]),
            .Pulse   (pulse[i])
        );
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        tick    = (pre == PRE_LAST);
        pre_nxt = tick ? '0 : pre + 1'b1;

        sum = {1'b0, Rem_Time}
            - SUM_W'(tick && (Rem_Time != '0))
            + (pulse[BTN_ADD_10]  ? SUM_W'(ADD_A) : '0)
            + (pulse[BTN_ADD_180] ? SUM_W'(ADD_B) : '0)
            + (pulse[BTN_ADD_200] ? SUM_W'(ADD_C) : '0)
            + (pulse[BTN_ADD_550] ? SUM_W'(ADD_D) : '0);

        rem_nxt = (sum > SUM_W'(MAX_TIME)) ? TIME_W'(MAX_TIME) : sum[TIME_W-1:0];

        // Loads override adds and the tick, and restart the second.
        if (pulse[BTN_LOAD_205]) begin
            rem_nxt = TIME_W'(LOAD_B);
            pre_nxt = '0;
        end else if (pulse[BTN_LOAD_10]) begin
            rem_nxt = TIME_W'(LOAD_A);
            pre_nxt = '0;
        end

        blank_nxt = blank_of(rem_nxt, pre_nxt >= PRE_HALF);
    end

    always_ff @(posedge SYS_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pre      <= '0;
            Rem_Time <= '0;
            Blank    <= 1'b0;
        end else begin
            pre      <= pre_nxt;
            Rem_Time <= rem_nxt;
            Blank    <= blank_nxt;
        end
    end

endmodule

// File: tb/tb_meter_timer.sv
// Scoreboard bench for meter_timer at CLK_HZ = 10: stimulus pushes cycle-stamped
// expectations, a negedge monitor pops and compares them.
module tb_meter_timer;

    localparam int A10  = 0;
    localparam int A180 = 1;
    localparam int A200 = 2;
    localparam int A550 = 3;
    localparam int L10  = 4;
    localparam int L205 = 5;

    typedef struct {
        int    at;
        int    rem;
        int    blank;
        string name;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [5:0]  btn;
    logic [15:0] rem_time;
    logic        blank;

    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    meter_timer #(.CLK_HZ(10), .DB_CYCLES(4)) dut (
        .SYS_CLK  (clk),
        .RESET_N  (rst_n),
        .Add_10   (btn[A10]),
        .Add_180  (btn[A180]),
        .Add_200  (btn[A200]),
        .Add_550  (btn[A550]),
        .Load_10  (btn[L10]),
        .Load_205 (btn[L205]),
        .Rem_Time (rem_time),
        .Blank    (blank)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic expect_at(input int at, input int rem, input int blk, input string name);
        exp_t e;
        e.at    = at;
        e.rem   = rem;
        e.blank = blk;
        e.name  = name;
        sb.push_back(e);
    endtask

    // Monitor: compare every expectation stamped for the current cycle.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            if (e.at < cyc) begin
                check({e.name, " missed"}, cyc, e.at);
            end else begin
                check({e.name, " rem"}, int'(rem_time), e.rem);
                check({e.name, " blank"}, int'(blank), e.blank);
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) wait_cyc(1);
    endtask

    task automatic press(input logic [5:0] m);
        btn = btn | m;
        wait_cyc(1);
        btn = btn & ~m;
        wait_cyc(1);
    endtask

    task automatic do_reset(output int base);
        rst_n = 1'b0;
        #1;
        check("reset async rem", int'(rem_time), 0);
        check("reset async blank", int'(blank), 0);
        wait_cyc(3);
        rst_n = 1'b1;
        base  = cyc;
    endtask

    initial begin
        int c;
        btn   = '0;
        rst_n = 1'b0;
        wait_cyc(2);

        // Reset: expired flash with a 5-cycle half period.
        do_reset(c);
        expect_at(c,      0, 0, "rst c0");
        expect_at(c + 4,  0, 0, "rst c4");
        expect_at(c + 5,  0, 1, "rst c5");
        expect_at(c + 9,  0, 1, "rst c9");
        expect_at(c + 10, 0, 0, "rst c10");
        expect_at(c + 15, 0, 1, "rst c15");
        wait_until(c + 16);

        // Coin adds, two edges of latency, then countdown.
        do_reset(c);
        expect_at(c + 2,  0,   0, "add before");
        expect_at(c + 3,  550, 0, "add 550");
        expect_at(c + 6,  550, 0, "add 550 hold");
        expect_at(c + 7,  750, 0, "add 200");
        expect_at(c + 9,  750, 0, "add pre tick");
        expect_at(c + 10, 749, 0, "add tick1");
        expect_at(c + 20, 748, 0, "add tick2");
        press(6'b1 << A550);
        wait_until(c + 4);
        press(6'b1 << A200);
        wait_until(c + 21);

        // Saturation at 9999, including an add landing on a tick.
        do_reset(c);
        expect_at(c + 3,  205,  0, "sat load205");
        expect_at(c + 37, 9552, 0, "sat 17 adds");
        expect_at(c + 39, 9999, 0, "sat clamp");
        expect_at(c + 41, 9999, 0, "sat clamp2");
        expect_at(c + 43, 9999, 0, "sat add10 tick");
        expect_at(c + 53, 9998, 0, "sat tick");
        press(6'b1 << L205);
        for (int i = 0; i < 19; i++) begin
            wait_until(c + 2 + 2 * i);
            press(6'b1 << A550);
        end
        wait_until(c + 40);
        press(6'b1 << A10);
        wait_until(c + 54);

        // Simultaneous events and load restarting the prescaler.
        do_reset(c);
        expect_at(c + 3,  10,  1, "sim load wins");
        expect_at(c + 8,  200, 0, "sim add 190");
        expect_at(c + 10, 200, 0, "sim pre reset");
        expect_at(c + 12, 200, 0, "sim pre tick");
        expect_at(c + 13, 199, 0, "sim tick");
        expect_at(c + 17, 10,  1, "sim load10");
        expect_at(c + 26, 10,  1, "sim load10 hold");
        expect_at(c + 27, 9,   0, "sim tick 9");
        expect_at(c + 76, 5,   0, "sim at 5");
        expect_at(c + 77, 14,  1, "sim add on tick");
        press((6'b1 << A10) | (6'b1 << A180) | (6'b1 << L10));
        wait_until(c + 5);
        press((6'b1 << A10) | (6'b1 << A180));
        wait_until(c + 14);
        press(6'b1 << L10);
        wait_until(c + 74);
        press(6'b1 << A10);
        wait_until(c + 78);

        // Low-time flash, expiry and hold at zero.
        do_reset(c);
        expect_at(c + 3,   10, 1, "low 10");
        expect_at(c + 12,  10, 1, "low 10 end");
        expect_at(c + 13,  9,  0, "low 9");
        expect_at(c + 23,  8,  1, "low 8");
        expect_at(c + 33,  7,  0, "low 7");
        expect_at(c + 93,  1,  0, "low 1");
        expect_at(c + 102, 1,  0, "low 1 end");
        expect_at(c + 103, 0,  0, "exp 0 ph0");
        expect_at(c + 107, 0,  0, "exp ph0 end");
        expect_at(c + 108, 0,  1, "exp ph1");
        expect_at(c + 112, 0,  1, "exp ph1 end");
        expect_at(c + 113, 0,  0, "exp no underflow");
        expect_at(c + 118, 0,  1, "exp ph1 again");
        expect_at(c + 123, 0,  0, "exp hold");
        press(6'b1 << L10);
        wait_until(c + 124);

        // Held button adds once; reset mid-count clears at once.
        do_reset(c);
        expect_at(c + 3,  200, 0, "held add");
        expect_at(c + 10, 199, 0, "held tick");
        expect_at(c + 49, 196, 1, "held no repeat");
        expect_at(c + 55, 195, 0, "held released");
        btn = 6'b1 << A200;
        wait_until(c + 50);
        btn = '0;
        wait_until(c + 57);
        #1;
        rst_n = 1'b0;
        #1;
        check("midcount reset rem", int'(rem_time), 0);
        check("midcount reset blank", int'(blank), 0);
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(2);

        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, " never compared"}, cyc, e.at);
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
